fft_dit_butterfly: RTL and testbench

Radix-2 decimation-in-time butterfly stage of the 32-point FFT datapath. It takes complex operands A and B and twiddle W, all signed Q-format fixed point. It computes X0 = A + B·W and X1 = A − B·W through a 3-stage valid/ready pipeline. The four real products come from the team's signed fixed-point multiply semantics, instantiated as a registered sub-module. The block feeds the inter-stage reorder buffer.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fxp_mul_reg.sv | 45 ++++
 rtl/fft_dit_butterfly.sv | 107 ++++++++++
 tb/tb_fft_dit_butterfly.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 32-point FFT datapath: word format, twiddle
// addressing and butterfly pipeline depth.
package fft_pkg;

   // Word width of every real/imag component (two's complement).
   localparam int N          = 16;
   // Fractional bits; 1.0 is represented as ONE.
   localparam int Q          = 8;
   localparam int ONE        = 1 << Q;
   // Width of one complex component (real or imaginary part).
   localparam int CW         = N;
   // Transform size and twiddle ROM addressing (N/2 distinct twiddles).
   localparam int FFT_POINTS = 32;
   localparam int TW_IDX_W   = $clog2(FFT_POINTS / 2);
   // Butterfly pipeline depth; the stage controller delays twiddle
   // addresses by this many cycles to line them up with results.
   localparam int BFLY_LAT   = 3;

endpackage

// File: rtl/fxp_mul_reg.sv
// Registered signed Q-format multiply. The full product's magnitude is
// truncated to W bits at the binary point (toward zero) and the sign is
// reapplied; bits above the kept field wrap away without saturation.
module fxp_mul_reg
   import fft_pkg::*;
#(
   parameter int W    = CW,
   parameter int FRAC = Q
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic        [W-1:0] p_o
);

   logic signed [2*W-1:0] full;
   logic        [2*W-1:0] mag;
   logic        [W-1:0]   trunc;
   logic                  neg;
   logic        [W-1:0]   p_d;
   logic        [W-1:0]   p_q;

   // Sign/magnitude product: truncate the magnitude, then restore the sign.
   always_comb begin
      full  = $signed({{W{a_i[W-1]}}, a_i}) * $signed({{W{b_i[W-1]}}, b_i});
      neg   = a_i[W-1] ^ b_i[W-1];
      mag   = full[2*W-1] ? $unsigned(-full) : $unsigned(full);
      trunc = W'(mag >> FRAC);
      p_d   = neg ? (~trunc + 1'b1) : trunc;
   end

   // Product register; holds while the pipeline is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else if (en_i) begin
         p_q <= p_d;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/fft_dit_butterfly.sv
// Radix-2 DIT butterfly: X0 = A + B*W, X1 = A - B*W, three-stage
// valid/ready pipeline with a single global stall driven by the output.
module fft_dit_butterfly
   import fft_pkg::*;
#(
   parameter int N     = fft_pkg::N,
   parameter int Q     = fft_pkg::Q,
   parameter int SCALE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a_re,
   input  logic [N-1:0] a_im,
   input  logic [N-1:0] b_re,
   input  logic [N-1:0] b_im,
   input  logic [N-1:0] w_re,
   input  logic [N-1:0] w_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] x0_re,
   output logic [N-1:0] x0_im,
   output logic [N-1:0] x1_re,
   output logic [N-1:0] x1_im
);

   logic stall;
   logic en;

   // Product order: 0 = re*re, 1 = im*im, 2 = re*im, 3 = im*re.
   logic [N-1:0] mul_b [4];
   logic [N-1:0] mul_w [4];
   logic [N-1:0] prod  [4];

   logic [N-1:0] a1_re_q, a1_im_q;
   logic         v1_q,    v1_d;
   logic [N-1:0] t_re_q,  t_re_d;
   logic [N-1:0] t_im_q,  t_im_d;
   logic [N-1:0] a2_re_q, a2_im_q;
   logic         v2_q;
   logic [N:0]   s0_re, s0_im, s1_re, s1_im;
   logic [N-1:0] x0_re_q, x0_re_d, x0_im_q, x0_im_d;
   logic [N-1:0] x1_re_q, x1_re_d, x1_im_q, x1_im_d;
   logic         v3_q;

   // Only an un-accepted valid result stops the pipe; bubbles never do.
   assign stall    = v3_q && !out_ready;
   assign en       = !stall;
   assign in_ready = !stall;

   assign mul_b[0] = b_re;  assign mul_w[0] = w_re;
   assign mul_b[1] = b_im;  assign mul_w[1] = w_im;
   assign mul_b[2] = b_re;  assign mul_w[2] = w_im;
   assign mul_b[3] = b_im;  assign mul_w[3] = w_re;

   for (genvar gi = 0; gi < 4; gi++) begin : g_mul
      fxp_mul_reg #(.W(N), .FRAC(Q)) u_mul (
         .clk  (clk),
         .rst  (rst),
         .en_i (en),
         .a_i  (mul_b[gi]),
         .b_i  (mul_w[gi]),
         .p_o  (prod[gi])
      );
   end

   // Stage-2 complex product and stage-3 butterfly sums (N+1 bits so the
   // optional halving keeps the true sign).
   always_comb begin
      v1_d    = in_valid && in_ready;
      t_re_d  = prod[0] - prod[1];
      t_im_d  = prod[2] + prod[3];
      s0_re   = {a2_re_q[N-1], a2_re_q} + {t_re_q[N-1], t_re_q};
      s0_im   = {a2_im_q[N-1], a2_im_q} + {t_im_q[N-1], t_im_q};
      s1_re   = {a2_re_q[N-1], a2_re_q} - {t_re_q[N-1], t_re_q};
      s1_im   = {a2_im_q[N-1], a2_im_q} - {t_im_q[N-1], t_im_q};
      x0_re_d = (SCALE != 0) ? s0_re[N:1] : s0_re[N-1:0];
      x0_im_d = (SCALE != 0) ? s0_im[N:1] : s0_im[N-1:0];
      x1_re_d = (SCALE != 0) ? s1_re[N:1] : s1_re[N-1:0];
      x1_im_d = (SCALE != 0) ? s1_im[N:1] : s1_im[N-1:0];
   end

   // Pipeline registers for all three stages, frozen together on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a1_re_q <= '0;  a1_im_q <= '0;  v1_q <= 1'b0;
         t_re_q  <= '0;  t_im_q  <= '0;
         a2_re_q <= '0;  a2_im_q <= '0;  v2_q <= 1'b0;
         x0_re_q <= '0;  x0_im_q <= '0;
         x1_re_q <= '0;  x1_im_q <= '0;  v3_q <= 1'b0;
      end else if (en) begin
         a1_re_q <= a_re;     a1_im_q <= a_im;     v1_q <= v1_d;
         t_re_q  <= t_re_d;   t_im_q  <= t_im_d;
         a2_re_q <= a1_re_q;  a2_im_q <= a1_im_q;  v2_q <= v1_q;
         x0_re_q <= x0_re_d;  x0_im_q <= x0_im_d;
         x1_re_q <= x1_re_d;  x1_im_q <= x1_im_d;  v3_q <= v2_q;
      end
   end

   assign out_valid = v3_q;
   assign x0_re     = x0_re_q;
   assign x0_im     = x0_im_q;
   assign x1_re     = x1_re_q;
   assign x1_im     = x1_im_q;

endmodule

// File: tb/tb_fft_dit_butterfly.sv
// Scoreboard bench for the butterfly: one unscaled and one scaled instance
// share stimulus; expected results come from an integer reference model.
module tb_fft_dit_butterfly;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;

   logic        ir0, ov0, ir1, ov1;
   logic [15:0] x0r0, x0i0, x1r0, x1i0;
   logic [15:0] x0r1, x0i1, x1r1, x1i1;

   always #5 clk = ~clk;

   fft_dit_butterfly #(.N(16), .Q(8), .SCALE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .out_valid(ov0), .out_ready(out_ready),
      .x0_re(x0r0), .x0_im(x0i0), .x1_re(x1r0), .x1_im(x1i0));

   fft_dit_butterfly #(.N(16), .Q(8), .SCALE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .out_valid(ov1), .out_ready(out_ready),
      .x0_re(x0r1), .x0_im(x0i1), .x1_re(x1r1), .x1_im(x1i1));

   typedef struct {
      logic [63:0] s0;     // {x0_re, x0_im, x1_re, x1_im}, SCALE=0
      logic [63:0] s1;     // same, SCALE=1
      int          t_acc;
      int          stalls;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   cycle = 0;
   int   stall_cnt = 0;

   // ---------------- reference model (plain integer arithmetic) ----------
   function automatic logic [15:0] lo16(input longint v);
      logic [63:0] t;
      t = v;
      return t[15:0];
   endfunction

   function automatic longint sx(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   // Real product in Q8: SV integer division truncates toward zero.
   function automatic longint qmul(input logic [15:0] x, input logic [15:0] y);
      return sx(lo16((sx(x) * sx(y)) / 256));
   endfunction

   function automatic exp_t model(input logic [15:0] ar, ai, br, bi, wr, wi);
      exp_t   e;
      longint tr, ti, p0r, p0i, p1r, p1i;
      tr  = sx(lo16(qmul(br, wr) - qmul(bi, wi)));
      ti  = sx(lo16(qmul(br, wi) + qmul(bi, wr)));
      p0r = sx(ar) + tr;  p0i = sx(ai) + ti;
      p1r = sx(ar) - tr;  p1i = sx(ai) - ti;
      e.s0 = {lo16(p0r), lo16(p0i), lo16(p1r), lo16(p1i)};
      e.s1 = {lo16(p0r >>> 1), lo16(p0i >>> 1), lo16(p1r >>> 1), lo16(p1i >>> 1)};
      e.t_acc = 0;
      e.stalls = 0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic        rst_seen;
      logic        prev_stall;
      logic [64:0] snap0, snap1;
      exp_t        e;
      rst_seen   = 1'b0;
      prev_stall = 1'b0;
      snap0 = '0;
      snap1 = '0;
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            if (!rst_seen) begin
               #1;
               chk("rst_dut0", {63'b0, ov0}, 64'd0);
               chk("rst_dut0_data", {x0r0, x0i0, x1r0, x1i0}, 64'd0);
               chk("rst_dut1", {63'b0, ov1}, 64'd0);
               chk("rst_dut1_data", {x0r1, x0i1, x1r1, x1i1}, 64'd0);
               sb.delete();
               rst_seen   = 1'b1;
               prev_stall = 1'b0;
            end
         end else begin
            rst_seen = 1'b0;
            cycle++;
            chk("in_ready", {63'b0, ir0}, {63'b0, !(ov0 && !out_ready)});
            chk("twin_state", {62'b0, ov1, ir1}, {62'b0, ov0, ir0});
            if (prev_stall) begin
               chk("stall_hold0", {ov0, x0r0, x0i0, x1r0, x1i0}, snap0);
               chk("stall_hold1", {ov1, x0r1, x0i1, x1r1, x1i1}, snap1);
            end
            if (ov0 && out_ready) begin
               if (sb.size() == 0) begin
                  chk("spurious_output", 64'd0, 64'd1);
               end else begin
                  e = sb.pop_front();
                  chk("result_scale0", {x0r0, x0i0, x1r0, x1i0}, e.s0);
                  chk("result_scale1", {x0r1, x0i1, x1r1, x1i1}, e.s1);
                  if (e.stalls == stall_cnt)
                     chk("latency", 64'(cycle - e.t_acc), 64'd3);
               end
            end
            if (in_valid && ir0) begin
               e = model(a_re, a_im, b_re, b_im, w_re, w_im);
               e.t_acc  = cycle;
               e.stalls = stall_cnt;
               sb.push_back(e);
            end
            prev_stall = ov0 && !out_ready;
            if (prev_stall) stall_cnt++;
            snap0 = {ov0, x0r0, x0i0, x1r0, x1i0};
            snap1 = {ov1, x0r1, x0i1, x1r1, x1i1};
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi);
      logic acc;
      acc = 1'b0;
      a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
      in_valid = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(negedge clk);
         acc = ir0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         $display("FAIL send_timeout: in_ready stayed low, required high within 100 cycles");
         $fatal(1, "input never accepted");
      end
   endtask

   task automatic wait_empty();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk);
         #1;
         done = (sb.size() == 0) && !ov0;
      end
      if (!done) begin
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
         $fatal(1, "pipeline did not drain");
      end
   endtask

   task automatic wait_out_valid();
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = ov0;
      end
      if (!seen) begin
         $display("FAIL out_valid_timeout: out_valid stayed 0, required 1 within 50 cycles");
         $fatal(1, "no output");
      end
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   logic rnd_on = 1'b0;

   initial begin : driver
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors: identity twiddle, -j twiddle, truncation, wrap/scale.
      send(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000);
      send(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'hFF00);
      send(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000);
      send(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000);
      send(16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0100, 16'h8000);
      wait_empty();

      // Backpressure: 5 back-to-back, 4-cycle output stall once valid rises.
      fork
         begin
            for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
         end
         begin
            wait_out_valid();
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_empty();

      // Asynchronous reset with vectors in flight, then a clean restart.
      send(16'h1234, 16'h0101, 16'h0200, 16'h0300, 16'h0100, 16'hFF00);
      send(16'h2222, 16'h0F0F, 16'h0400, 16'hFC00, 16'h00B5, 16'hFF4B);
      send(16'h3333, 16'h7000, 16'h7FFF, 16'h8000, 16'h00B5, 16'h00B5);
      wait_out_valid();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      send(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000);
      wait_empty();

      // Randomized traffic with random backpressure and input gaps.
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
            end
            rnd_on = 1'b0;
         end
      join
      wait_empty();
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
